// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//   Input conditioning for the slide-switch / select inputs ({S, sw}) that
//   feed the 3-8 decoder and breathing-LED path. Each bit is synchronised
//   with two flops and then filtered. A new level is accepted only after it
//   has persisted for DEBOUNCE_CNT consecutive cycles. Each accepted toggle
//   produces a single-cycle strobe.
//
//   Optional feature macro: SWDB_EDGE_EN adds the rise/fall strobe ports.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   raw_in     in   WIDTH  asynchronous raw switch levels
//   sw_stable  out  WIDTH  debounced levels
//   changed    out  WIDTH  1-cycle pulse per bit on each accepted toggle
//   any_change out  1      OR of changed, same cycle
//   rise       out  WIDTH  (SWDB_EDGE_EN) 1-cycle pulse on accepted 0->1
//   fall       out  WIDTH  (SWDB_EDGE_EN) 1-cycle pulse on accepted 1->0
// ---------------------------------------------------------------------------
module switch_debouncer #(
    parameter int unsigned WIDTH        = 6,
    parameter int unsigned DEBOUNCE_CNT = 240000,
    parameter int unsigned CNT_W        = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] changed,
    output logic             any_change
`ifdef SWDB_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    // Per-bit state is implied by whether the synchronised input disagrees
    // with the accepted level; no separate state flops are kept.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } db_state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CNT - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] changed_nxt;

    // Next-state: count mismatch cycles, accept on reaching the window end.
    always_comb begin
        db_state_e st;
        st          = ST_IDLE;
        stable_nxt  = sw_stable;
        changed_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            st = (sync2[i] != sw_stable[i]) ? ST_COUNT : ST_IDLE;
            case (st)
                ST_IDLE: begin
                    // Bounce back to the accepted level restarts the window.
                    cnt_nxt[i] = '0;
                end
                ST_COUNT: begin
                    if (cnt[i] == LAST_CNT) begin
                        stable_nxt[i]  = sync2[i];
                        changed_nxt[i] = 1'b1;
                        cnt_nxt[i]     = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: cnt_nxt[i] = '0;
            endcase
        end
    end

    // State register: synchroniser, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            sw_stable  <= '0;
            changed    <= '0;
            any_change <= 1'b0;
`ifdef SWDB_EDGE_EN
            rise       <= '0;
            fall       <= '0;
`endif
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= raw_in;
            sync2      <= sync1;
            sw_stable  <= stable_nxt;
            changed    <= changed_nxt;
            any_change <= |changed_nxt;
`ifdef SWDB_EDGE_EN
            rise       <= changed_nxt & stable_nxt;
            fall       <= changed_nxt & ~stable_nxt;
`endif
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
